// File: rtl/uart_tx_cfg_if.sv
// uart_tx_cfg_if: host-side character, configuration and line signals of the configurable UART transmitter
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W = 16
);
  logic [DATA_BITS-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [DIV_W-1:0] baud_div;
  logic [1:0] parity_mode;
  logic two_stop;
  logic txd;
  logic busy;
  logic tx_done;
  modport master (
    output tx_data, tx_valid, baud_div, parity_mode, two_stop,
    input tx_ready, txd, busy, tx_done
  );
  modport slave (
    input tx_data, tx_valid, baud_div, parity_mode, two_stop,
    output tx_ready, txd, busy, tx_done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: UART transmitter with runtime baud divisor, selectable parity and 1 or 2 stop bits
module uart_tx_cfg #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W = 16
) (
  input logic clk,
  input logic reset,
  uart_tx_cfg_if.slave bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
  state_t state_q, state_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [DIV_W-1:0] div_q, div_d, cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic par_en_q, par_en_d, par_bit_q, par_bit_d;
  logic two_q, two_d, stop_q, stop_d;
  logic txd_q, txd_d, busy_q, busy_d, done_q, done_d;
  logic tick;
  assign bus.tx_ready = (state_q == IDLE) && !reset;
  assign bus.txd = txd_q;
  assign bus.busy = busy_q;
  assign bus.tx_done = done_q;
  always_comb begin
    tick = cnt_q == div_q;
    state_d = state_q;
    data_d = data_q;
    div_d = div_q;
    bit_d = bit_q;
    par_en_d = par_en_q;
    par_bit_d = par_bit_q;
    two_d = two_q;
    stop_d = stop_q;
    txd_d = txd_q;
    case (state_q)
      IDLE: if (bus.tx_valid && bus.tx_ready) begin
        state_d = START;
        data_d = bus.tx_data;
        div_d = bus.baud_div;
        par_en_d = |bus.parity_mode;
        par_bit_d = (bus.parity_mode == 2'b11) | ((^bus.tx_data) ^ (bus.parity_mode == 2'b10));
        two_d = bus.two_stop;
        bit_d = '0;
        stop_d = 1'b0;
        txd_d = 1'b0;
      end
      START: if (tick) begin
        state_d = DATA;
        txd_d = data_q[0];
        data_d = data_q >> 1;
      end
      DATA: if (tick) begin
        if (bit_q == LAST_BIT) begin
          state_d = par_en_q ? PARITY : STOP;
          txd_d = par_en_q ? par_bit_q : 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          txd_d = data_q[0];
          data_d = data_q >> 1;
        end
      end
      PARITY: if (tick) begin
        state_d = STOP;
        txd_d = 1'b1;
      end
      STOP: if (tick) begin
        state_d = (stop_q == two_q) ? IDLE : STOP;
        stop_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
        txd_d = 1'b1;
      end
    endcase
    cnt_d = (tick || state_q == IDLE || state_d == IDLE) ? '0 : cnt_q + 1'b1;
    done_d = (state_d == STOP) && (cnt_d == div_q) && (stop_d == two_q);
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      data_q <= '0;
      div_q <= '0;
      cnt_q <= '0;
      bit_q <= '0;
      par_en_q <= 1'b0;
      par_bit_q <= 1'b0;
      two_q <= 1'b0;
      stop_q <= 1'b0;
      txd_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      div_q <= div_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      par_en_q <= par_en_d;
      par_bit_q <= par_bit_d;
      two_q <= two_d;
      stop_q <= stop_d;
      txd_q <= txd_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed self-checking bench for the configurable UART transmitter
module tb_uart_tx_cfg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  uart_tx_cfg_if #(.DATA_BITS(8), .DIV_W(16)) b8 ();
  uart_tx_cfg_if #(.DATA_BITS(5), .DIV_W(16)) b5 ();
  uart_tx_cfg #(.DATA_BITS(8), .DIV_W(16)) dut8 (.clk(clk), .reset(reset), .bus(b8));
  uart_tx_cfg #(.DATA_BITS(5), .DIV_W(16)) dut5 (.clk(clk), .reset(reset), .bus(b5));
  int vectors = 0;
  int miscompares = 0;
  logic txd_log [0:255];
  logic done_log [0:255];
  logic busy_log [0:255];
  logic rdy_log [0:255];
  function automatic logic [3:0] exp_at(input string s, input int p, input int c);
    int n = s.len() * p;
    return (c == n) ? 4'b1001 : {s[c/p] == "1", c == n - 1, 2'b10};
  endfunction
  task automatic send(input logic sel, input logic [7:0] d, input logic [15:0] dv, input logic [1:0] pm, input logic ts, input int m);
    int k = 0;
    if (sel) begin
      b5.tx_data = d[4:0];
      b5.baud_div = dv;
      b5.parity_mode = pm;
      b5.two_stop = ts;
      b5.tx_valid = 1'b1;
    end else begin
      b8.tx_data = d;
      b8.baud_div = dv;
      b8.parity_mode = pm;
      b8.two_stop = ts;
      b8.tx_valid = 1'b1;
    end
    while (!(sel ? b5.tx_ready : b8.tx_ready) && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    vectors++;
    if (k == 200) begin
      miscompares++;
      $display("FAIL send_ready: tx_ready=0 after 200 cycles, required 1");
    end
    @(posedge clk); #1;
    b5.tx_valid = 1'b0;
    b8.tx_valid = 1'b0;
    for (int c = 0; c < m; c++) begin
      txd_log[c] = sel ? b5.txd : b8.txd;
      done_log[c] = sel ? b5.tx_done : b8.tx_done;
      busy_log[c] = sel ? b5.busy : b8.busy;
      rdy_log[c] = sel ? b5.tx_ready : b8.tx_ready;
      @(posedge clk); #1;
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({b8.txd, b8.busy, b8.tx_done, b8.tx_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_state8 txd,busy,done,ready=%b required 1000", {b8.txd, b8.busy, b8.tx_done, b8.tx_ready});
    end
    vectors++;
    if ({b5.txd, b5.busy, b5.tx_done, b5.tx_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_state5 txd,busy,done,ready=%b required 1000", {b5.txd, b5.busy, b5.tx_done, b5.tx_ready});
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({b8.tx_ready, b5.tx_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_release ready8,ready5=%b required 11", {b8.tx_ready, b5.tx_ready});
    end
  endtask
  task automatic test_8n1();
    string s = "0101001011";
    send(1'b0, 8'hA5, 16'd3, 2'b00, 1'b0, 41);
    for (int c = 0; c <= 40; c++) begin
      vectors++;
      if ({txd_log[c], done_log[c], busy_log[c], rdy_log[c]} !== exp_at(s, 4, c)) begin
        miscompares++;
        $display("FAIL 8n1 cycle %0d txd,done,busy,ready=%b required %b", c, {txd_log[c], done_log[c], busy_log[c], rdy_log[c]}, exp_at(s, 4, c));
      end
    end
  endtask
  task automatic test_parity();
    string pat [4] = '{"010100101011", "01010010111", "010000000111", "01000000001"};
    logic [7:0] dat [4] = '{8'hA5, 8'hA5, 8'h01, 8'h01};
    logic [1:0] pm [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic ts [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      int n = pat[i].len() * 4;
      send(1'b0, dat[i], 16'd3, pm[i], ts[i], n + 1);
      for (int c = 0; c <= n; c++) begin
        vectors++;
        if ({txd_log[c], done_log[c], busy_log[c], rdy_log[c]} !== exp_at(pat[i], 4, c)) begin
          miscompares++;
          $display("FAIL parity case %0d cycle %0d txd,done,busy,ready=%b required %b", i, c, {txd_log[c], done_log[c], busy_log[c], rdy_log[c]}, exp_at(pat[i], 4, c));
        end
      end
    end
  endtask
  task automatic test_back_to_back();
    string t = "0101010101101111111111";
    string d = "0000000001000000000010";
    string r = "0000000000100000000001";
    b8.tx_data = 8'h55;
    b8.baud_div = 16'd0;
    b8.parity_mode = 2'b00;
    b8.two_stop = 1'b0;
    b8.tx_valid = 1'b1;
    vectors++;
    if (b8.tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready_before tx_ready=%b required 1", b8.tx_ready);
    end
    @(posedge clk); #1;
    b8.tx_data = 8'hFF;
    for (int c = 0; c < 22; c++) begin
      logic [3:0] e;
      if (c == 11) b8.tx_valid = 1'b0;
      e = {t[c] == "1", d[c] == "1", r[c] != "1", r[c] == "1"};
      vectors++;
      if ({b8.txd, b8.tx_done, b8.busy, b8.tx_ready} !== e) begin
        miscompares++;
        $display("FAIL b2b cycle %0d txd,done,busy,ready=%b required %b", c, {b8.txd, b8.tx_done, b8.busy, b8.tx_ready}, e);
      end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_cfg_change();
    string s1 = "0001111001";
    string s2 = "00011110001";
    b8.tx_data = 8'h3C;
    b8.baud_div = 16'd7;
    b8.parity_mode = 2'b00;
    b8.two_stop = 1'b0;
    b8.tx_valid = 1'b1;
    vectors++;
    if (b8.tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cfg_ready_before tx_ready=%b required 1", b8.tx_ready);
    end
    @(posedge clk); #1;
    b8.tx_valid = 1'b0;
    for (int c = 0; c <= 80; c++) begin
      if (c == 19) begin
        b8.baud_div = 16'd1;
        b8.parity_mode = 2'b01;
      end
      vectors++;
      if ({b8.txd, b8.tx_done, b8.busy, b8.tx_ready} !== exp_at(s1, 8, c)) begin
        miscompares++;
        $display("FAIL cfg_old cycle %0d txd,done,busy,ready=%b required %b", c, {b8.txd, b8.tx_done, b8.busy, b8.tx_ready}, exp_at(s1, 8, c));
      end
      @(posedge clk); #1;
    end
    send(1'b0, 8'h3C, 16'd1, 2'b01, 1'b0, 23);
    for (int c = 0; c <= 22; c++) begin
      vectors++;
      if ({txd_log[c], done_log[c], busy_log[c], rdy_log[c]} !== exp_at(s2, 2, c)) begin
        miscompares++;
        $display("FAIL cfg_new cycle %0d txd,done,busy,ready=%b required %b", c, {txd_log[c], done_log[c], busy_log[c], rdy_log[c]}, exp_at(s2, 2, c));
      end
    end
  endtask
  task automatic test_five_bit_mark();
    string pat [2] = '{"01111111", "00000011"};
    logic [7:0] dat [2] = '{8'h1F, 8'h00};
    for (int i = 0; i < 2; i++) begin
      send(1'b1, dat[i], 16'd1, 2'b11, 1'b0, 17);
      for (int c = 0; c <= 16; c++) begin
        vectors++;
        if ({txd_log[c], done_log[c], busy_log[c], rdy_log[c]} !== exp_at(pat[i], 2, c)) begin
          miscompares++;
          $display("FAIL 5bit_mark case %0d cycle %0d txd,done,busy,ready=%b required %b", i, c, {txd_log[c], done_log[c], busy_log[c], rdy_log[c]}, exp_at(pat[i], 2, c));
        end
      end
    end
  endtask
  task automatic test_reset_mid_frame();
    int bad = 0;
    b8.tx_data = 8'h00;
    b8.baud_div = 16'd3;
    b8.parity_mode = 2'b00;
    b8.two_stop = 1'b0;
    b8.tx_valid = 1'b1;
    vectors++;
    if (b8.tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_ready_before tx_ready=%b required 1", b8.tx_ready);
    end
    @(posedge clk); #1;
    b8.tx_valid = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    vectors++;
    if ({b8.txd, b8.busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_mid_bit3 txd,busy=%b required 01", {b8.txd, b8.busy});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if ({b8.txd, b8.busy, b8.tx_done, b8.tx_ready} !== 4'b1000) begin
      miscompares++;
      $display("FAIL rst_mid_abort txd,busy,done,ready=%b required 1000", {b8.txd, b8.busy, b8.tx_done, b8.tx_ready});
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (b8.tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid_ready_after tx_ready=%b required 1", b8.tx_ready);
    end
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if ({b8.txd, b8.tx_done, b8.busy} !== 3'b100) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL rst_mid_quiet %0d cycles with txd/done/busy off idle, required 0", bad);
    end
  endtask
  initial begin
    b8.tx_valid = 1'b0;
    b8.tx_data = '0;
    b8.baud_div = '0;
    b8.parity_mode = 2'b00;
    b8.two_stop = 1'b0;
    b5.tx_valid = 1'b0;
    b5.tx_data = '0;
    b5.baud_div = '0;
    b5.parity_mode = 2'b00;
    b5.two_stop = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_cfg_change();
    test_five_bit_mark();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
